// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Read-side consumer for a show-ahead FIFO. It pulls words through the FIFO's
// read-request/empty handshake and packs RATIO consecutive words, LSB-first,
// into one wide word. The wide word leaves through a registered valid/ready
// stream. A flush request pushes out a partially filled word together with
// the number of slots that hold data.
//
// Ports:
//   clk_i          single clock
//   srst_i         synchronous active-high reset
//   fifo_empty_i   FIFO empty flag
//   fifo_q_i       FIFO show-ahead data, valid while not empty
//   fifo_rd_req_o  read request; consumes fifo_q_i in the same cycle
//   flush_i        single-cycle request to emit the pending partial word
//   src_data_o     packed word, slot k at [k*DWIDTH +: DWIDTH]
//   src_cnt_o      number of valid slots in src_data_o (1..RATIO)
//   src_valid_o    output word valid
//   src_ready_i    downstream accept

module fifo_rd_packer #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4,
  parameter int CWIDTH = $clog2(RATIO+1)
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     fifo_empty_i,
  input  logic [DWIDTH-1:0]        fifo_q_i,
  output logic                     fifo_rd_req_o,
  input  logic                     flush_i,
  output logic [DWIDTH*RATIO-1:0]  src_data_o,
  output logic [CWIDTH-1:0]        src_cnt_o,
  output logic                     src_valid_o,
  input  logic                     src_ready_i
);

  localparam int IW = $clog2(RATIO);

  // Only RATIO-1 slots are stored; the final word of a full pack goes
  // straight from fifo_q_i into the output register.
  logic [DWIDTH*(RATIO-1)-1:0] r_acc;
  logic [IW-1:0]               r_idx;
  logic                        r_flushPend;
  logic [DWIDTH*RATIO-1:0]     r_data;
  logic [CWIDTH-1:0]           r_cnt;
  logic                        r_valid;

  logic          w_outFree;
  logic          w_lastSlot;
  logic          w_rdReq;
  logic [IW-1:0] w_idxNext;

  // The completing read may only happen when the output register can take
  // the new word; earlier slots fill regardless of backpressure. Reads stop
  // entirely while a flush is waiting to load.
  always_comb begin
    w_outFree  = !r_valid || src_ready_i;
    w_lastSlot = (r_idx == IW'(RATIO-1));
    w_rdReq    = !srst_i && !fifo_empty_i && !r_flushPend &&
                 (!w_lastSlot || w_outFree);
  end

  // Slot index after this cycle's read, used to decide whether a flush
  // request has anything to emit (a word read in the flush cycle counts).
  always_comb begin
    w_idxNext = r_idx;
    if (w_rdReq) begin
      w_idxNext = w_lastSlot ? '0 : r_idx + IW'(1);
    end
  end

  // Accumulator, output register and flush bookkeeping. A load into the
  // output register later in the block overrides the drain of the previous
  // word, giving bubble-free replacement.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_acc       <= '0;
      r_idx       <= '0;
      r_flushPend <= 1'b0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
    end else begin
      if (r_valid && src_ready_i) begin
        r_valid <= 1'b0;
      end

      if (r_flushPend) begin
        if (w_outFree) begin
          r_data      <= {{DWIDTH{1'b0}}, r_acc};
          r_cnt       <= CWIDTH'(r_idx);
          r_valid     <= 1'b1;
          r_acc       <= '0;
          r_idx       <= '0;
          r_flushPend <= 1'b0;
        end
      end else begin
        if (w_rdReq) begin
          if (w_lastSlot) begin
            r_data  <= {fifo_q_i, r_acc};
            r_cnt   <= CWIDTH'(RATIO);
            r_valid <= 1'b1;
            r_acc   <= '0;
            r_idx   <= '0;
          end else begin
            for (int k = 0; k < RATIO-1; k++) begin
              if (r_idx == IW'(k)) begin
                r_acc[k*DWIDTH +: DWIDTH] <= fifo_q_i;
              end
            end
            r_idx <= r_idx + IW'(1);
          end
        end
        if (flush_i && (w_idxNext != '0)) begin
          r_flushPend <= 1'b1;
        end
      end
    end
  end

  assign fifo_rd_req_o = w_rdReq;
  assign src_data_o    = r_data;
  assign src_cnt_o     = r_cnt;
  assign src_valid_o   = r_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer
// Drives fifo_rd_packer from a queue-based FIFO and compares every cycle
// against a list-based reference: accepted words are collected in a queue
// and packed whenever RATIO of them arrive or a flush becomes effective.

module tb_fifo_rd_packer;

  localparam int DWIDTH = 8;
  localparam int RATIO  = 4;
  localparam int CWIDTH = $clog2(RATIO+1);
  localparam int WW     = DWIDTH*RATIO;

  logic              clk_i = 1'b0;
  logic              srst_i;
  logic              fifo_empty_i;
  logic [DWIDTH-1:0] fifo_q_i;
  logic              fifo_rd_req_o;
  logic              flush_i;
  logic [WW-1:0]     src_data_o;
  logic [CWIDTH-1:0] src_cnt_o;
  logic              src_valid_o;
  logic              src_ready_i;

  int checks   = 0;
  int failures = 0;

  logic [DWIDTH-1:0] fifoQ[$];
  logic [DWIDTH-1:0] accList[$];
  bit                mPend  = 1'b0;
  bit                mValid = 1'b0;
  logic [WW-1:0]     mData  = '0;
  int                mCnt   = 0;

  fifo_rd_packer #(.DWIDTH(DWIDTH), .RATIO(RATIO)) dut (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_q_i      (fifo_q_i),
    .fifo_rd_req_o (fifo_rd_req_o),
    .flush_i       (flush_i),
    .src_data_o    (src_data_o),
    .src_cnt_o     (src_cnt_o),
    .src_valid_o   (src_valid_o),
    .src_ready_i   (src_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [WW-1:0] packWords();
    logic [WW-1:0] w;
    w = '0;
    foreach (accList[k]) w[k*DWIDTH +: DWIDTH] = accList[k];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expectWord(input string tag, input logic [WW-1:0] d, input int c);
    checkOutput({tag, "_valid"}, 64'(src_valid_o), 64'(1));
    checkOutput({tag, "_data"}, 64'(src_data_o), 64'(d));
    checkOutput({tag, "_cnt"}, 64'(src_cnt_o), 64'(c));
  endtask

  // One clock cycle: drive inputs, check the read request before the edge,
  // advance the reference at the edge, check the output register after it.
  task automatic applyStimulus(input bit rst, input bit flush, input bit ready);
    bit                empty;
    bit                outFree;
    bit                expRd;
    logic [DWIDTH-1:0] q;
    empty = (fifoQ.size() == 0);
    q = empty ? DWIDTH'($urandom) : fifoQ[0];
    srst_i       = rst;
    flush_i      = flush;
    src_ready_i  = ready;
    fifo_empty_i = empty;
    fifo_q_i     = q;
    #1;
    outFree = !mValid || ready;
    expRd = !rst && !empty && !mPend && (accList.size() != RATIO-1 || outFree);
    checkOutput("rd_req", 64'(fifo_rd_req_o), 64'(expRd));
    @(posedge clk_i);
    if (rst) begin
      accList.delete();
      mPend  = 1'b0;
      mValid = 1'b0;
      mData  = '0;
      mCnt   = 0;
    end else begin
      if (mValid && ready) mValid = 1'b0;
      if (mPend) begin
        if (outFree) begin
          mData  = packWords();
          mCnt   = accList.size();
          mValid = 1'b1;
          mPend  = 1'b0;
          accList.delete();
        end
      end else begin
        if (expRd) begin
          accList.push_back(q);
          void'(fifoQ.pop_front());
          if (accList.size() == RATIO) begin
            mData  = packWords();
            mCnt   = RATIO;
            mValid = 1'b1;
            accList.delete();
          end
        end
        if (flush && accList.size() != 0) mPend = 1'b1;
      end
    end
    #1;
    checkOutput("valid", 64'(src_valid_o), 64'(mValid));
    if (mValid || rst) begin
      checkOutput("data", 64'(src_data_o), 64'(mData));
      checkOutput("cnt", 64'(src_cnt_o), 64'(mCnt));
    end
  endtask

  initial begin
    // Reset with a non-empty FIFO: no read may be requested.
    fifoQ.push_back(8'h5A);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    checkOutput("reset_data", 64'(src_data_o), 64'(0));
    fifoQ.delete();

    // Streaming of one full word, valid for exactly one cycle.
    fifoQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (4) applyStimulus(0, 0, 1);
    expectWord("stream", 32'h44332211, 4);
    applyStimulus(0, 0, 1);
    checkOutput("stream_one_cycle", 64'(src_valid_o), 64'(0));

    // Backpressure: three reads, stall, then bubble-free replacement.
    fifoQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (4) applyStimulus(0, 0, 1);
    for (int i = 1; i <= 8; i++) fifoQ.push_back(DWIDTH'(i));
    repeat (5) applyStimulus(0, 0, 0);
    expectWord("bp_hold", 32'h44332211, 4);
    applyStimulus(0, 0, 1);
    expectWord("bp_release", 32'h04030201, 4);
    repeat (4) applyStimulus(0, 0, 1);
    expectWord("bp_second", 32'h08070605, 4);
    applyStimulus(0, 0, 1);

    // Partial flush, then the next word starts in slot 0.
    fifoQ = '{8'hAA, 8'hBB};
    repeat (2) applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 1);
    expectWord("flush_partial", 32'h0000BBAA, 2);
    fifoQ = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    repeat (4) applyStimulus(0, 0, 1);
    expectWord("after_flush", 32'hC4C3C2C1, 4);
    applyStimulus(0, 0, 1);

    // Flush with nothing pending is a no-op.
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 1);
    checkOutput("flush_idle_none", 64'(src_valid_o), 64'(0));

    // Flush together with the completing read: only the full word.
    fifoQ = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    repeat (3) applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    expectWord("flush_full", 32'hD4D3D2D1, 4);
    repeat (2) applyStimulus(0, 0, 1);
    checkOutput("flush_full_no_extra", 64'(src_valid_o), 64'(0));

    // Flush together with the second read: partial word of two.
    fifoQ = '{8'hE1, 8'hE2};
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 1);
    expectWord("flush_second", 32'h0000E2E1, 2);
    applyStimulus(0, 0, 1);

    // Reset mid-operation discards the pending word and partial slots.
    fifoQ = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'h71, 8'h72};
    repeat (4) applyStimulus(0, 0, 1);
    repeat (2) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("midrst_valid", 64'(src_valid_o), 64'(0));
    fifoQ = '{8'h81, 8'h82, 8'h83, 8'h84};
    repeat (4) applyStimulus(0, 0, 1);
    expectWord("midrst_word", 32'h84838281, 4);
    applyStimulus(0, 0, 1);

    // Randomized traffic with flushes, backpressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) != 0 && fifoQ.size() < 16) fifoQ.push_back(DWIDTH'($urandom));
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Single-clock read-side consumer for the show-ahead dual-clock FIFO. It drains FIFO words through the FIFO's read-request/empty interface and packs RATIO consecutive words, LSB-first, into one wide word. The wide word is presented on a valid/ready stream with an output register. A flush input forces out a partially filled word together with its word count.

## Interface
Parameters:
- DWIDTH, 8, width of one FIFO word.
- RATIO, 4, FIFO words per output word; legal values ≥ 2.
- CWIDTH, $clog2(RATIO+1), width of the word-count output (derived, do not override).

Ports:
- clk_i  in  1  single clock; one clock domain throughout.
- srst_i  in  1  reset, synchronous and active-high.
- fifo_empty_i  in  1  FIFO read-side empty flag.
- fifo_q_i  in  DWIDTH  FIFO show-ahead data; valid whenever fifo_empty_i=0.
- fifo_rd_req_o  out  1  FIFO read request; consumes the word on fifo_q_i in the same cycle.
- flush_i  in  1  single-cycle request to emit the pending partial word.
- src_data_o  out  DWIDTH*RATIO  packed word; slot k occupies bits [k*DWIDTH +: DWIDTH].
- src_cnt_o  out  CWIDTH  number of valid slots in src_data_o (1..RATIO).
- src_valid_o  out  1  output word valid.
- src_ready_i  in  1  downstream accepts the word when src_valid_o=1 and src_ready_i=1.

## Operation
Internal state:
- acc: RATIO-1 slot registers.
- idx: next slot index, 0..RATIO-1.
- flush_pend: registered flush-pending flag.
- The output register holds src_data_o, src_cnt_o and src_valid_o.

Definitions:
- out_free = !src_valid_o || src_ready_i.
- fifo_rd_req_o = !srst_i && !fifo_empty_i && !flush_pend && (idx != RATIO-1 || out_free). This output is combinational.
- A read is accepted in any cycle where fifo_rd_req_o=1.

Accepted read with idx < RATIO-1:
- Write fifo_q_i into acc slot idx.
- Increment idx.

Accepted read with idx = RATIO-1:
- Load the output register with {fifo_q_i, acc slots RATIO-2..0}.
- Set src_cnt_o to RATIO and src_valid_o to 1.
- Clear acc and set idx to 0.

Output register:
- When src_valid_o=1 and src_ready_i=1 with no new load, src_valid_o goes to 0 next cycle.
- While src_valid_o=1 and src_ready_i=0, src_data_o and src_cnt_o hold stable.

Flush handling:
- flush_i is sampled every cycle while flush_pend=0.
- flush_pend is set if idx_next ≠ 0 after any read accepted in that same cycle. A word read in the flush cycle is therefore included in the flush.
- flush_i with idx_next = 0 is a no-op.
- flush_i while flush_pend=1 is ignored.

flush_pend=1 and out_free=1:
- Load the output register with acc. Unfilled slots are zero.
- Set src_cnt_o to idx and src_valid_o to 1.
- Clear acc, set idx to 0 and clear flush_pend.
- No FIFO reads are performed while flush_pend=1.

Reset (srst_i=1 at a rising edge):
- src_valid_o=0, src_data_o=0, src_cnt_o=0.
- idx=0, acc=0, flush_pend=0.
- fifo_rd_req_o is 0 throughout any cycle with srst_i=1.
- A mid-operation reset discards the partial word and any pending output; no word is emitted.

## Timing
- Full word: the RATIO-th read is accepted in cycle N; src_valid_o=1 in cycle N+1.
- Back-to-back: with src_ready_i=1 and the FIFO never empty, fifo_rd_req_o stays 1 continuously. One output word is produced every RATIO cycles.
- Backpressure, with src_valid_o=1 and src_ready_i=0:
  - Up to RATIO-1 further reads are accepted.
  - fifo_rd_req_o then drops to 0 while idx = RATIO-1.
  - When src_ready_i rises, the completing read and the output replacement happen in the same cycle with no bubble.
- Flush:
  - flush_i in cycle N sets flush_pend for cycle N+1.
  - If out_free holds in cycle N+1, the partial word is valid in cycle N+2. Otherwise it is valid in the cycle after out_free first holds.
  - Reads resume in the cycle after the partial word loads.
- Empty FIFO: fifo_rd_req_o=0 and no state changes except output draining and flush.

## Test plan
1. Reset: srst_i=1 for 2 cycles with fifo_empty_i=0 and fifo_q_i=0x5A -> fifo_rd_req_o=0 both cycles; src_valid_o, src_data_o and src_cnt_o all 0 afterwards.
2. Streaming, DWIDTH=8, RATIO=4: FIFO supplies 0x11,0x22,0x33,0x44 back-to-back with src_ready_i=1 -> fifo_rd_req_o high for 4 cycles; one cycle after the 4th read, src_data_o=0x44332211, src_cnt_o=4, src_valid_o=1 for exactly one cycle.
3. Backpressure: src_ready_i=0 with word 0x44332211 valid and 8 words in the FIFO -> exactly 3 more reads, then fifo_rd_req_o=0 and src_data_o stable. Raising src_ready_i -> 4th read accepted the same cycle; the next cycle shows the new word with no idle cycle.
4. Partial flush: FIFO supplies 0xAA, 0xBB, then empty; flush_i pulsed -> two cycles later src_data_o=0x0000BBAA, src_cnt_o=2, src_valid_o=1; the next word packs into slot 0.
5. Flush corner cases:
   - flush_i with idx=0 -> no output.
   - flush_i in the same cycle as the 4th read -> only the full word (cnt=4) is emitted.
   - flush_i in the same cycle as the 2nd read -> partial word with cnt=2.
6. Reset mid-operation: idx=2 and src_valid_o=1 with src_ready_i=0; assert srst_i for one cycle -> outputs 0; the next 4 reads yield a word built from those 4 reads only.
